program_loader: RTL and testbench

- Front-end loader that sits directly upstream of the single-cycle processor core.
- Receives a program as a byte stream over a valid/ready handshake and assembles each group of 4 bytes into a 32-bit instruction word.
- Writes the words into instruction memory through the core's we/d/a load port, holds the core in reset while loading, then asserts exec to run the program.

---
 rtl/program_loader.sv | 191 +++++++++++++++++++
 tb/tb_program_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: turns a byte stream into 32-bit instruction words for the core's load port.
// The core is held in reset while the program loads, and it runs once the load completes.
// Frame format: a 2-byte big-endian word count N, then N big-endian words.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte over the data bytes.
module program_loader #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_WORDS = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              we_o,
  output logic [DATA_W-1:0] d_o,
  output logic [ADDR_W-1:0] a_o,
  output logic              proc_rst_o,
  output logic              exec_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StData, StWrite, StRun, StError
`ifdef LOADER_CHECKSUM_EN
    , StChk
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [15:0]         idx_q, idx_d;
  logic [1:0]          lane_q, lane_d;
  // The first three bytes of the current word; the fourth byte arrives directly from in_data_i.
  logic [DATA_W-9:0]   word_q, word_d;
  logic [DATA_W-1:0]   d_q, d_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic                in_ready_q, in_ready_d;
  logic                we_q, we_d;
  logic                proc_rst_q, proc_rst_d;
  logic                exec_q, exec_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  assign accept = in_valid_i & in_ready_q;

  // Next-state logic; each output is decoded from the next state so that it is registered.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    word_d  = word_q;
    d_d     = d_q;
    a_d     = a_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      StIdle, StRun, StError: begin
        if (start_i) state_d = StHdr0;
      end
      StHdr0: begin
        if (accept) begin
          count_d = {in_data_i, 8'h00};
          state_d = StHdr1;
        end
      end
      StHdr1: begin
        if (accept) begin
          count_d = {count_q[15:8], in_data_i};
          if (count_d == 16'd0 || count_d > 16'(MAX_WORDS)) begin
            state_d = StError;
          end else begin
            state_d = StData;
            idx_d   = 16'd0;
            lane_d  = 2'd0;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_d = {word_q[DATA_W-17:0], in_data_i};
          lane_d = lane_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data_i;
`endif
          if (lane_q == 2'd3) begin
            state_d = StWrite;
            d_d     = {word_q, in_data_i};
            a_d     = idx_q[ADDR_W-1:0];
          end
        end
      end
      StWrite: begin
        idx_d = idx_q + 16'd1;
        if (idx_d == count_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StRun;
`endif
        end else begin
          state_d = StData;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (accept) state_d = (in_data_i == csum_q) ? StRun : StError;
      end
`endif
      default: state_d = StIdle;
    endcase
`ifdef LOADER_CHECKSUM_EN
    // A fresh frame starts its checksum from zero.
    if (state_d == StHdr0 && state_q != StHdr0) csum_d = 8'h00;
`endif

    in_ready_d = (state_d == StHdr0) || (state_d == StHdr1) || (state_d == StData);
    busy_d     = in_ready_d || (state_d == StWrite);
`ifdef LOADER_CHECKSUM_EN
    in_ready_d = in_ready_d || (state_d == StChk);
    busy_d     = busy_d || (state_d == StChk);
`endif
    we_d       = (state_d == StWrite);
    proc_rst_d = (state_d != StRun);
    exec_d     = (state_d == StRun);
    done_d     = (state_d == StRun);
    err_d      = (state_d == StError);
  end

  // State and registered outputs; reset is asynchronous and active-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      idx_q      <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      d_q        <= '0;
      a_q        <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      proc_rst_q <= 1'b1;
      exec_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      d_q        <= d_d;
      a_q        <= a_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      proc_rst_q <= proc_rst_d;
      exec_q     <= exec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign in_ready_o = in_ready_q;
  assign we_o       = we_q;
  assign d_o        = d_q;
  assign a_o        = a_q;
  assign proc_rst_o = proc_rst_q;
  assign exec_o     = exec_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: drives directed frames, and a scoreboard checks every write.
module tb_program_loader;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready_o, we_o, proc_rst_o, exec_o, busy_o, done_o, err_o;
  logic [DATA_W-1:0] d_o;
  logic [ADDR_W-1:0] a_o;

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(512)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready_o),
    .we_o       (we_o),
    .d_o        (d_o),
    .a_o        (a_o),
    .proc_rst_o (proc_rst_o),
    .exec_o     (exec_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] tb_csum;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && we_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_we: got a=%0h d=%0h, expected no write", a_o, d_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("we_addr", 64'(a_o), 64'(mon_e.a));
        chk("we_data", 64'(d_o), 64'(mon_e.d));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    @(negedge clk);
    for (int i = 0; i < gap; i++) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept: in_ready got 0 after 50 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    tb_csum = 8'h00;
    send_byte(n[15:8], 0);
    send_byte(n[7:0], 0);
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w, input bit rnd);
    logic [7:0] b;
    exp_q.push_back('{a: addr, d: w});
    for (int i = 0; i < 4; i++) begin
      b = w[31-8*i -: 8];
      tb_csum = tb_csum ^ b;
      send_byte(b, rnd ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  task automatic finish_frame();
`ifdef LOADER_CHECKSUM_EN
    send_byte(tb_csum, 0);
`endif
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // which: 0 waits for done, 1 waits for err.
  task automatic wait_for(input int which, input string name);
    int t;
    t = 0;
    while (((which == 0) ? !done_o : !err_o) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'((which == 0) ? done_o : err_o), 64'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_we", 64'(we_o), 64'd0);
    chk("rst_d", 64'(d_o), 64'd0);
    chk("rst_a", 64'(a_o), 64'd0);
    chk("rst_proc_rst", 64'(proc_rst_o), 64'd1);
    chk("rst_exec", 64'(exec_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready_o), 64'd0);

    // Basic two-word program.
    do_start();
    chk("hdr0_in_ready", 64'(in_ready_o), 64'd1);
    chk("hdr0_busy", 64'(busy_o), 64'd1);
    send_hdr(16'd2);
    send_word(9'd0, 32'h2001_0005, 1'b0);
    send_word(9'd1, 32'h2002_000A, 1'b0);
    finish_frame();
    wait_for(0, "run_done");
    chk("run_exec", 64'(exec_o), 64'd1);
    chk("run_proc_rst", 64'(proc_rst_o), 64'd0);
    chk("run_busy", 64'(busy_o), 64'd0);
    chk("run_in_ready", 64'(in_ready_o), 64'd0);
    chk("run_pending", 64'(exp_q.size()), 64'd0);

    // Restart from RUN, then a zero-length header.
    do_start();
    chk("restart_exec", 64'(exec_o), 64'd0);
    chk("restart_done", 64'(done_o), 64'd0);
    chk("restart_proc_rst", 64'(proc_rst_o), 64'd1);
    chk("restart_in_ready", 64'(in_ready_o), 64'd1);
    send_hdr(16'd0);
    wait_for(1, "n0_err");
    chk("n0_exec", 64'(exec_o), 64'd0);
    chk("n0_in_ready", 64'(in_ready_o), 64'd0);
    chk("n0_proc_rst", 64'(proc_rst_o), 64'd1);
    do_start();
    chk("clr_err", 64'(err_o), 64'd0);
    chk("clr_in_ready", 64'(in_ready_o), 64'd1);

    // Oversized count (513 words).
    send_hdr(16'h0201);
    wait_for(1, "n513_err");
    chk("n513_busy", 64'(busy_o), 64'd0);
    do_start();

    // Three words with randomly gapped in_valid.
    send_hdr(16'd3);
    send_word(9'd0, 32'h1122_3344, 1'b1);
    send_word(9'd1, 32'hA5A5_5A5A, 1'b1);
    send_word(9'd2, 32'hDEAD_BEEF, 1'b1);
    finish_frame();
    wait_for(0, "gap_done");
    chk("gap_pending", 64'(exp_q.size()), 64'd0);

    // Reset mid-frame, after six data bytes.
    do_start();
    send_hdr(16'd3);
    send_word(9'd0, 32'hCAFE_F00D, 1'b0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("mid_rst_we", 64'(we_o), 64'd0);
    chk("mid_rst_d", 64'(d_o), 64'd0);
    chk("mid_rst_a", 64'(a_o), 64'd0);
    chk("mid_rst_proc_rst", 64'(proc_rst_o), 64'd1);
    chk("mid_rst_exec", 64'(exec_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_pending", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_start();
    send_hdr(16'd2);
    send_word(9'd0, 32'h0000_0013, 1'b0);
    send_word(9'd1, 32'hFFFF_FFFF, 1'b0);
    finish_frame();
    wait_for(0, "reload_done");
    chk("reload_exec", 64'(exec_o), 64'd1);

`ifdef LOADER_CHECKSUM_EN
    // 01^02^03^04 = 04.
    do_start();
    send_hdr(16'd1);
    send_word(9'd0, 32'h0102_0304, 1'b0);
    send_byte(8'h04, 0);
    wait_for(0, "csum_ok_done");
    do_start();
    send_hdr(16'd1);
    send_word(9'd0, 32'h0102_0304, 1'b0);
    send_byte(8'h05, 0);
    wait_for(1, "csum_bad_err");
    chk("csum_bad_exec", 64'(exec_o), 64'd0);
`endif

    repeat (3) @(negedge clk);
    chk("final_pending", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
